scope_capture: RTL

SCOPE_CAPTURE -- requirements
Module: scope_capture

---
 rtl/scope_pkg.sv | 25 ++
 rtl/scope_capture_if.sv | 12 +
 rtl/scope_trigger.sv | 91 +++++++++
 rtl/scope_capture.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/scope_pkg.sv
// Shared types and helpers for the scope capture block: FSM state encoding,
// trigger edge selects and a constant clog2.
package scope_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StPre  = 3'd1,
    StWait = 3'd2,
    StPost = 3'd3,
    StDone = 3'd4
  } scope_state_e;

  localparam logic EdgeRising  = 1'b0;
  localparam logic EdgeFalling = 1'b1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/scope_capture_if.sv
// Sample stream into the scope: one-cycle valid strobe plus all channels packed,
// channel 0 in the LSBs.
interface scope_capture_if #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DATA_W   = 12
);
  logic                         sample_valid;
  logic [CHANNELS*DATA_W-1:0]   ch_data;

  modport master (output sample_valid, output ch_data);
  modport slave  (input  sample_valid, input  ch_data);
endinterface

// File: rtl/scope_trigger.sv
// Edge detector on the selected trigger channel: holds the previous accepted sample
// and, when SCOPE_AUTO_TRIG_EN is defined, a WAIT-state timeout that forces a trigger.
module scope_trigger
  import scope_pkg::*;
#(
  parameter int unsigned DATA_W       = 12,
  parameter int unsigned AUTO_TIMEOUT = 4096
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              accept_i,
  input  logic              wait_i,
  input  logic [DATA_W-1:0] sample_i,
  input  logic [DATA_W-1:0] level_i,
  input  logic              edge_i,
  output logic              fire_o
);

  if (AUTO_TIMEOUT == 0) begin : g_bad_timeout
    $error("scope_trigger: AUTO_TIMEOUT must be non-zero");
  end

  logic [DATA_W-1:0] prev_q, prev_d;
  logic              prev_vld_q, prev_vld_d;
  logic              edge_hit;

  always_comb begin
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    if (clr_i) begin
      prev_vld_d = 1'b0;
    end else if (accept_i) begin
      prev_d     = sample_i;
      prev_vld_d = 1'b1;
    end
  end

  always_comb begin
    edge_hit = 1'b0;
    if (prev_vld_q) begin
      case (edge_i)
        EdgeRising:  edge_hit = (prev_q < level_i) && (sample_i >= level_i);
        EdgeFalling: edge_hit = (prev_q > level_i) && (sample_i <= level_i);
        default:     edge_hit = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
    end
  end

`ifdef SCOPE_AUTO_TRIG_EN
  localparam int unsigned ToW = clog2(AUTO_TIMEOUT + 1);

  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           timeout;

  // The AUTO_TIMEOUT-th edgeless sample in WAIT is itself forced as the trigger.
  assign timeout = (to_cnt_q == ToW'(AUTO_TIMEOUT - 1));

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (clr_i || !wait_i) begin
      to_cnt_d = '0;
    end else if (accept_i) begin
      to_cnt_d = to_cnt_q + ToW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  assign fire_o = accept_i && wait_i && (edge_hit || timeout);
`else
  assign fire_o = accept_i && wait_i && edge_hit;
`endif

endmodule

// File: rtl/scope_capture.sv
// Triggered multi-channel capture into a circular buffer with pre-trigger history
// and display readback. Define SCOPE_AUTO_TRIG_EN to enable the forced-trigger timeout.
module scope_capture
  import scope_pkg::*;
#(
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned DATA_W       = 12,
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned PRETRIG      = 256,
  parameter int unsigned AUTO_TIMEOUT = 4096,
  localparam int unsigned ADDR_W      = clog2(DEPTH),
  localparam int unsigned TRIG_CH_W   = (CHANNELS > 1) ? clog2(CHANNELS) : 1
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  scope_capture_if.slave             sample_if,
  input  logic                       arm_i,
  input  logic                       continuous_i,
  input  logic                       frame_end_i,
  input  logic [TRIG_CH_W-1:0]       trig_ch_i,
  input  logic [DATA_W-1:0]          trig_level_i,
  input  logic                       trig_edge_i,
  input  logic [7:0]                 decim_i,
  input  logic [10:0]                rd_x_i,
  output logic [CHANNELS*DATA_W-1:0] rd_data_o,
  output logic [2:0]                 state_o,
  output logic                       triggered_o,
  output logic                       resample_o
);

  if (DEPTH < 8 || (DEPTH & (DEPTH - 1)) != 0 || PRETRIG < 1 || PRETRIG > DEPTH - 2)
  begin : g_bad_params
    $error("scope_capture: illegal DEPTH/PRETRIG combination");
  end

  scope_state_e              state_q, state_d;
  logic [ADDR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]         trig_ptr_q, trig_ptr_d;
  logic [ADDR_W-1:0]         cnt_q, cnt_d;
  logic [7:0]                dec_cnt_q, dec_cnt_d;
  logic                      triggered_q, triggered_d;
  logic                      resample_q, resample_d;
  logic                      cap_valid_q, cap_valid_d;
  logic                      rd_zero_q;
  logic [CHANNELS*DATA_W-1:0] ram_rd_q;
  logic [CHANNELS*DATA_W-1:0] mem_q [DEPTH];

  logic              accept, arm_eff, capturing, we, fire;
  logic [DATA_W-1:0] trig_sample;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_in_range;

  assign accept    = sample_if.sample_valid && (dec_cnt_q == decim_i);
  assign arm_eff   = arm_i || ((state_q == StDone) && continuous_i && frame_end_i);
  assign capturing = (state_q == StPre) || (state_q == StWait) || (state_q == StPost);
  assign we        = accept && capturing && !arm_eff;

  // Out-of-range channel selects fall back to channel 0.
  always_comb begin
    trig_sample = sample_if.ch_data[DATA_W-1:0];
    for (int unsigned c = 1; c < CHANNELS; c++) begin
      if (32'(trig_ch_i) == c) trig_sample = sample_if.ch_data[c*DATA_W +: DATA_W];
    end
  end

  scope_trigger #(
    .DATA_W       (DATA_W),
    .AUTO_TIMEOUT (AUTO_TIMEOUT)
  ) u_trigger (
    .clk_i    (clock_i),
    .rst_i    (reset_i),
    .clr_i    (arm_eff),
    .accept_i (accept && !arm_eff),
    .wait_i   (state_q == StWait),
    .sample_i (trig_sample),
    .level_i  (trig_level_i),
    .edge_i   (trig_edge_i),
    .fire_o   (fire)
  );

  always_comb begin
    dec_cnt_d = dec_cnt_q;
    if (arm_eff) begin
      dec_cnt_d = '0;
    end else if (sample_if.sample_valid) begin
      dec_cnt_d = accept ? 8'd0 : dec_cnt_q + 8'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    trig_ptr_d  = trig_ptr_q;
    cnt_d       = cnt_q;
    cap_valid_d = cap_valid_q;
    triggered_d = 1'b0;
    resample_d  = 1'b0;
    if (arm_eff) begin
      state_d  = StPre;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else if (accept) begin
      case (state_q)
        StPre: begin
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          if (cnt_q == ADDR_W'(PRETRIG - 1)) begin
            state_d = StWait;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
        StWait: begin
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          if (fire) begin
            state_d     = StPost;
            trig_ptr_d  = wr_ptr_q;
            triggered_d = 1'b1;
            cnt_d       = '0;
          end
        end
        StPost: begin
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          if (cnt_q == ADDR_W'(DEPTH - PRETRIG - 2)) begin
            state_d     = StDone;
            resample_d  = 1'b1;
            cap_valid_d = 1'b1;
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      trig_ptr_q  <= '0;
      cnt_q       <= '0;
      dec_cnt_q   <= '0;
      triggered_q <= 1'b0;
      resample_q  <= 1'b0;
      cap_valid_q <= 1'b0;
      rd_zero_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      trig_ptr_q  <= trig_ptr_d;
      cnt_q       <= cnt_d;
      dec_cnt_q   <= dec_cnt_d;
      triggered_q <= triggered_d;
      resample_q  <= resample_d;
      cap_valid_q <= cap_valid_d;
      rd_zero_q   <= !(cap_valid_q && rd_in_range);
    end
  end

  // Column 0 maps to the oldest pre-trigger sample.
  assign rd_addr     = trig_ptr_q - ADDR_W'(PRETRIG) + ADDR_W'(rd_x_i);
  assign rd_in_range = 32'(rd_x_i) < DEPTH;

  always_ff @(posedge clock_i) begin
    if (we) mem_q[wr_ptr_q] <= sample_if.ch_data;
    ram_rd_q <= mem_q[rd_addr];
  end

  assign rd_data_o   = rd_zero_q ? '0 : ram_rd_q;
  assign state_o     = state_q;
  assign triggered_o = triggered_q;
  assign resample_o  = resample_q;

endmodule
